// File: rtl/seg_readback_decoder.sv
// Readback decoder for the three-digit active-low 7-segment bus: filters, decodes mode/value.
// Optional SEG_READBACK_SYNC2_EN adds a two-flop input synchronizer ahead of the sample register.
module seg_readback_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [20:0] seg_n,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [1:0]  out_mode,
    output logic [3:0]  out_value,
    output logic        out_err
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

    localparam logic [6:0] GlyphH = 7'b1110110;
    localparam logic [6:0] GlyphD = 7'b1011110;
    localparam logic [6:0] GlyphB = 7'b1111100;
    localparam logic [6:0] Glyph0 = 7'b0111111;
    localparam logic [6:0] Glyph1 = 7'b0000110;

    typedef enum logic [1:0] {StWaitStable, StDecode, StHold} state_e;

    logic [20:0] bus_in;
    logic        bus_vld;

`ifdef SEG_READBACK_SYNC2_EN
    logic [20:0] sync1_q, sync2_q;
    logic        sv1_q, sv2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            sv1_q   <= 1'b0;
            sv2_q   <= 1'b0;
        end else begin
            sync1_q <= seg_n;
            sync2_q <= sync1_q;
            sv1_q   <= 1'b1;
            sv2_q   <= sv1_q;
        end
    end

    assign bus_in  = sync2_q;
    assign bus_vld = sv2_q;
`else
    assign bus_in  = seg_n;
    assign bus_vld = 1'b1;
`endif

    logic [20:0] sample_q, prev_q, cand_q, cand_d, last_q, last_d;
    logic        sample_vld_q, prev_vld_q, last_vld_q, last_vld_d;
    logic [7:0]  cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  value_q, value_d;
    logic        err_q, err_d;
    logic        same, stable, new_pat;

    // The valid flags keep reset contents of the pipeline from counting as a real sample.
    assign same    = sample_vld_q && prev_vld_q && (sample_q == prev_q);
    assign stable  = same && (cnt_q == CntMax);
    assign new_pat = !last_vld_q || (sample_q != last_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    function automatic logic [4:0] glyph_val(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'b0111111: r = {1'b1, 4'h0};
            7'b0000110: r = {1'b1, 4'h1};
            7'b1011011: r = {1'b1, 4'h2};
            7'b1001111: r = {1'b1, 4'h3};
            7'b1100110: r = {1'b1, 4'h4};
            7'b1101101: r = {1'b1, 4'h5};
            7'b1111101: r = {1'b1, 4'h6};
            7'b0000111: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1101111: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b1111100: r = {1'b1, 4'hB};
            7'b0111001: r = {1'b1, 4'hC};
            7'b1011110: r = {1'b1, 4'hD};
            7'b1111001: r = {1'b1, 4'hE};
            7'b1110001: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [6:0] d2, d1, d0;
    logic [4:0] g0;
    logic [1:0] dec_mode;
    logic [3:0] dec_value;
    logic       dec_err;

    assign d2 = cand_q[20:14];
    assign d1 = cand_q[13:7];
    assign d0 = cand_q[6:0];
    assign g0 = glyph_val(d0);

    always_comb begin
        dec_mode  = 2'b00;
        dec_value = 4'h0;
        dec_err   = 1'b0;
        if (cand_q == '0) begin
            dec_err = 1'b0;
        end else if (d2 == GlyphH && d1 == 7'b0 && g0[4]) begin
            dec_mode  = 2'b01;
            dec_value = g0[3:0];
        end else if (d2 == GlyphD && d1 == Glyph0 && g0[4] && g0[3:0] <= 4'd9) begin
            dec_mode  = 2'b10;
            dec_value = g0[3:0];
        end else if (d2 == GlyphD && d1 == Glyph1 && g0[4] && g0[3:0] <= 4'd5) begin
            dec_mode  = 2'b10;
            dec_value = g0[3:0] + 4'd10;
        end else if (d2 == GlyphB && d1 == 7'b0 && g0[4] && g0[3:0] <= 4'd9) begin
            dec_mode  = 2'b11;
            dec_value = g0[3:0];
        end else begin
            dec_err = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        mode_d     = mode_q;
        value_d    = value_q;
        err_d      = err_q;
        unique case (state_q)
            StWaitStable: begin
                if (stable && new_pat) begin
                    state_d = StDecode;
                    cand_d  = sample_q;
                end
            end
            StDecode: begin
                mode_d     = dec_mode;
                value_d    = dec_value;
                err_d      = dec_err;
                last_d     = cand_q;
                last_vld_d = 1'b1;
                state_d    = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StWaitStable;
                end
            end
            default: state_d = StWaitStable;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StWaitStable;
            cand_q       <= '0;
            last_q       <= '0;
            last_vld_q   <= 1'b0;
            mode_q       <= 2'b00;
            value_q      <= 4'h0;
            err_q        <= 1'b0;
        end else begin
            sample_q     <= ~bus_in;
            sample_vld_q <= bus_vld;
            prev_q       <= sample_q;
            prev_vld_q   <= sample_vld_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            last_q       <= last_d;
            last_vld_q   <= last_vld_d;
            mode_q       <= mode_d;
            value_q      <= value_d;
            err_q        <= err_d;
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_mode  = mode_q;
    assign out_value = value_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Scoreboard bench for seg_readback_decoder: stimulus pushes expected results, a monitor pops them.
module tb_seg_readback_decoder;

    localparam int S = 4;
`ifdef SEG_READBACK_SYNC2_EN
    localparam int LAT = S + 4;
`else
    localparam int LAT = S + 2;
`endif

    localparam logic [6:0] SH   = 7'b1110110;
    localparam logic [6:0] SD   = 7'b1011110;
    localparam logic [6:0] SB   = 7'b1111100;
    localparam logic [6:0] SOFF = 7'b0000000;
    localparam logic [6:0] S0   = 7'b0111111;
    localparam logic [6:0] S1   = 7'b0000110;
    localparam logic [6:0] S2   = 7'b1011011;
    localparam logic [6:0] S3   = 7'b1001111;
    localparam logic [6:0] S5   = 7'b1101101;
    localparam logic [6:0] S6   = 7'b1111101;
    localparam logic [6:0] S7   = 7'b0000111;
    localparam logic [6:0] S9   = 7'b1101111;
    localparam logic [6:0] SA   = 7'b1110111;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] seg_n;
    logic        out_ready;
    logic        out_valid;
    logic [1:0]  out_mode;
    logic [3:0]  out_value;
    logic        out_err;

    seg_readback_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_n     (seg_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_mode  (out_mode),
        .out_value (out_value),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] value;
        logic       err;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;

    function automatic logic [20:0] bus(input logic [6:0] a, input logic [6:0] b,
                                        input logic [6:0] c);
        return ~{a, b, c};
    endfunction

    function automatic res_t mk(input logic [1:0] m, input logic [3:0] v, input logic e);
        res_t r;
        r.mode  = m;
        r.value = v;
        r.err   = e;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) valid_cnt++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_report", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("mode", int'(out_mode), int'(e.mode));
                check("value", int'(out_value), int'(e.value));
                check("err", int'(out_err), int'(e.err));
            end
        end
    end

    task automatic drive(input logic [20:0] v);
        @(posedge clk);
        #2 seg_n = v;
    endtask

    // Counts edges from the first sampling edge (n=1) until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    int n;
    int snap;

    initial begin
        reset     = 1'b1;
        seg_n     = '1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_mode", int'(out_mode), 0);
        check("rst_value", int'(out_value), 0);
        check("rst_err", int'(out_err), 0);

        // Blank after reset is reported exactly once.
        exp_q.push_back(mk(2'b00, 4'h0, 1'b0));
        @(posedge clk);
        #2 reset = 1'b0;
        wait_valid(n);
        check("lat_blank", n, LAT + 1);
        repeat (20) @(posedge clk);

        exp_q.push_back(mk(2'b01, 4'hA, 1'b0));
        drive(bus(SH, SOFF, SA));
        wait_valid(n);
        check("lat_hexA", n, LAT + 1);
        @(posedge clk);
        #1 check("valid_one_cycle", int'(out_valid), 0);

        exp_q.push_back(mk(2'b10, 4'd13, 1'b0));
        drive(bus(SD, S1, S3));
        wait_valid(n);
        check("lat_dec13", n, LAT + 1);

        exp_q.push_back(mk(2'b00, 4'h0, 1'b1));
        drive(bus(SD, S1, S6));
        wait_valid(n);

        // Backpressure: b9 must stay frozen while the bus moves on to H5.
        exp_q.push_back(mk(2'b11, 4'd9, 1'b0));
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        seg_n     = bus(SB, SOFF, S9);
        wait_valid(n);
        exp_q.push_back(mk(2'b01, 4'd5, 1'b0));
        drive(bus(SH, SOFF, S5));
        repeat (10) begin
            @(posedge clk);
            #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_value", int'(out_value), 9);
            check("hold_mode", int'(out_mode), 3);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_valid(n);
        check("h5_valid", int'(out_valid), 1);

        // Patterns held S-1 samples never settle; ending on the last report gives no report.
        @(posedge clk);
        snap = valid_cnt;
        for (int i = 0; i < 8; i++) begin
            drive((i % 2 == 0) ? bus(SH, SOFF, S1) : bus(SH, SOFF, S2));
            repeat (S - 2) @(posedge clk);
        end
        drive(bus(SH, SOFF, S5));
        repeat (15) @(posedge clk);
        check("toggle_no_report", valid_cnt - snap, 0);

        // Reset while holding a result discards it at once.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        seg_n     = bus(SH, SOFF, S7);
        wait_valid(n);
        check("pre_rst_hold", int'(out_valid), 1);
        #1 reset = 1'b1;
        #1;
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_mode", int'(out_mode), 0);
        check("rst_hold_value", int'(out_value), 0);
        repeat (2) @(posedge clk);
        exp_q.push_back(mk(2'b01, 4'd7, 1'b0));
        out_ready = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        wait_valid(n);
        check("lat_after_rst", n, LAT + 1);

        repeat (10) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
